// File: rtl/clk_tick_gen.sv
// Multi-channel clock-enable generator: per-channel tick pulse and square wave
// with runtime-loadable divisors, pause, shadowed reload and phase-aligned restart.
module clk_tick_gen #(
   parameter int                       NUM_CH   = 2,
   parameter int                       CNT_W    = 20,
   parameter int                       SEL_W    = 1,
   parameter logic [NUM_CH*CNT_W-1:0]  DIV_INIT = {20'd1000000, 20'd100000}
) (
   input  logic              clk_in_100m_hz,
   input  logic              rst,
   input  logic [NUM_CH-1:0] en,
   input  logic              sync_restart,
   input  logic              div_wr,
   input  logic [SEL_W-1:0]  div_sel,
   input  logic [CNT_W-1:0]  div_data,
   output logic [NUM_CH-1:0] div_pending,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] clk_out
);

   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];
   logic [CNT_W-1:0]  cnt_nx [NUM_CH];
   logic [CNT_W-1:0]  div_q [NUM_CH];
   logic [CNT_W-1:0]  div_d [NUM_CH];
   logic [CNT_W-1:0]  shd_q [NUM_CH];
   logic [CNT_W-1:0]  shd_d [NUM_CH];
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic [NUM_CH-1:0] clk_q, clk_d;
   logic [NUM_CH-1:0] wr_hit;
   logic [NUM_CH-1:0] wrap;

   function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
      return (v < CNT_W'(2)) ? CNT_W'(2) : v;
   endfunction

   // The active divisor always takes the shadow at a wrap or restart: when
   // nothing is pending the shadow already equals the active divisor.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         wr_hit[i] = div_wr && (div_sel == SEL_W'(i));
         wrap[i]   = en[i] && (cnt_q[i] == div_q[i] - CNT_W'(1));
         cnt_nx[i] = wrap[i] ? '0 : cnt_q[i] + CNT_W'(1);

         cnt_d[i]  = cnt_q[i];
         div_d[i]  = div_q[i];
         shd_d[i]  = wr_hit[i] ? clamp_div(div_data) : shd_q[i];
         pend_d[i] = pend_q[i] | wr_hit[i];
         tick_d[i] = 1'b0;
         clk_d[i]  = 1'b0;

         if (sync_restart) begin
            cnt_d[i]  = '0;
            div_d[i]  = shd_q[i];
            pend_d[i] = wr_hit[i];
         end else if (en[i]) begin
            cnt_d[i]  = cnt_nx[i];
            tick_d[i] = wrap[i];
            clk_d[i]  = cnt_nx[i] < (div_q[i] >> 1);
            if (wrap[i]) begin
               div_d[i]  = shd_q[i];
               pend_d[i] = wr_hit[i];
            end
         end
      end
   end

   always_ff @(posedge clk_in_100m_hz) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
            div_q[i] <= clamp_div(DIV_INIT[i*CNT_W +: CNT_W]);
            shd_q[i] <= clamp_div(DIV_INIT[i*CNT_W +: CNT_W]);
         end
         pend_q <= '0;
         tick_q <= '0;
         clk_q  <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
            div_q[i] <= div_d[i];
            shd_q[i] <= shd_d[i];
         end
         pend_q <= pend_d;
         tick_q <= tick_d;
         clk_q  <= clk_d;
      end
   end

   assign div_pending = pend_q;
   assign tick        = tick_q;
   assign clk_out     = clk_q;

endmodule

// File: tb/tb_clk_tick_gen.sv
// Scoreboard bench for clk_tick_gen: a period/age model predicts every cycle's
// outputs, a separate monitor pops and compares on the falling edge.
module tb_clk_tick_gen;

   localparam int NUM_CH = 2;
   localparam int CNT_W  = 4;
   localparam int SEL_W  = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NUM_CH-1:0] en = '0;
   logic              sync_restart = 1'b0;
   logic              div_wr = 1'b0;
   logic [SEL_W-1:0]  div_sel = '0;
   logic [CNT_W-1:0]  div_data = '0;
   logic [NUM_CH-1:0] div_pending, tick, clk_out;

   clk_tick_gen #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEL_W(SEL_W),
      .DIV_INIT({4'd5, 4'd4})
   ) dut (
      .clk_in_100m_hz(clk), .rst(rst), .en(en), .sync_restart(sync_restart),
      .div_wr(div_wr), .div_sel(div_sel), .div_data(div_data),
      .div_pending(div_pending), .tick(tick), .clk_out(clk_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NUM_CH-1:0] t;
      logic [NUM_CH-1:0] c;
      logic [NUM_CH-1:0] p;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference: each channel has a period D, a staged next period S, a pending
   // flag and the number of running cycles since its period began.
   int m_per[NUM_CH];
   int m_next[NUM_CH];
   int m_age[NUM_CH];
   bit m_pend[NUM_CH];
   int init_per[NUM_CH] = '{4, 5};

   function automatic int at_least2(input int v);
      return (v < 2) ? 2 : v;
   endfunction

   task automatic cyc(input bit r, input logic [NUM_CH-1:0] e, input bit sr,
                      input bit wr, input int sel, input int data);
      exp_t x;
      @(negedge clk);
      #1;
      rst = r; en = e; sync_restart = sr; div_wr = wr;
      div_sel = SEL_W'(sel); div_data = CNT_W'(data);
      x = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (r) begin
            m_per[ch] = at_least2(init_per[ch]);
            m_next[ch] = m_per[ch];
            m_age[ch] = 0;
            m_pend[ch] = 0;
         end else begin
            if (sr) begin
               m_age[ch] = 0;
               if (m_pend[ch]) begin m_per[ch] = m_next[ch]; m_pend[ch] = 0; end
            end else if (e[ch]) begin
               m_age[ch]++;
               if (m_age[ch] == m_per[ch]) begin
                  x.t[ch] = 1'b1;
                  m_age[ch] = 0;
                  if (m_pend[ch]) begin m_per[ch] = m_next[ch]; m_pend[ch] = 0; end
               end
               x.c[ch] = (m_age[ch] < m_per[ch] / 2);
            end
            if (wr && sel == ch) begin
               m_next[ch] = at_least2(data);
               m_pend[ch] = 1;
            end
         end
         x.p[ch] = m_pend[ch];
      end
      exp_q.push_back(x);
   endtask

   task automatic run(input int n, input logic [NUM_CH-1:0] e);
      for (int k = 0; k < n; k++) cyc(0, e, 0, 0, 0, 0);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks++;
            if (tick !== x.t) begin
               errors++;
               $display("FAIL tick: got %b expected %b at %0t", tick, x.t, $time);
            end
            checks++;
            if (clk_out !== x.c) begin
               errors++;
               $display("FAIL clk_out: got %b expected %b at %0t", clk_out, x.c, $time);
            end
            checks++;
            if (div_pending !== x.p) begin
               errors++;
               $display("FAIL div_pending: got %b expected %b at %0t", div_pending, x.p, $time);
            end
         end
      end
   end

   initial begin : driver
      int guard;
      logic [NUM_CH-1:0] e_r;
      // Reset state and default periods 4 / 5
      for (int k = 0; k < 3; k++) cyc(1, 2'b00, 0, 0, 0, 0);
      run(30, 2'b11);
      // Mid-period writes: 3, then 0 (clamped to 2)
      run(2, 2'b11);
      cyc(0, 2'b11, 0, 1, 0, 3);
      run(20, 2'b11);
      cyc(0, 2'b11, 0, 1, 0, 0);
      run(10, 2'b11);
      // Write landing exactly on a ch0 wrap, after arming a pending value
      cyc(0, 2'b11, 0, 1, 0, 6);
      guard = 0;
      while (m_age[0] != m_per[0] - 1 && guard < 20) begin
         run(1, 2'b11);
         guard++;
      end
      cyc(0, 2'b11, 0, 1, 0, 3);
      run(25, 2'b11);
      // Out-of-range channel select
      cyc(0, 2'b11, 0, 1, 3, 7);
      run(10, 2'b11);
      // Pause ch1 for 7 cycles, including a write while paused
      run(3, 2'b11);
      cyc(0, 2'b01, 0, 1, 1, 9);
      run(6, 2'b01);
      run(25, 2'b11);
      // Phase-aligned restart, one with a same-cycle write
      cyc(0, 2'b11, 0, 1, 1, 4);
      run(2, 2'b11);
      cyc(0, 2'b11, 1, 0, 0, 0);
      run(20, 2'b11);
      cyc(0, 2'b10, 1, 1, 0, 5);
      run(20, 2'b11);
      // Reset mid-period with pending writes
      cyc(0, 2'b11, 0, 1, 0, 11);
      run(2, 2'b11);
      cyc(1, 2'b11, 0, 0, 0, 0);
      run(15, 2'b11);
      // Random traffic
      e_r = 2'b11;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(19) == 0) e_r = NUM_CH'($urandom_range(3));
         cyc($urandom_range(199) == 0, e_r, $urandom_range(49) == 0,
             $urandom_range(7) == 0, int'($urandom_range(3)), int'($urandom_range(15)));
      end
      run(3, 2'b11);
      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      #2;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
